// File: rtl/tick_pkg.sv
// Shared types and defaults for the tick period meter.
package tick_pkg;

    localparam int unsigned DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURING  = 2'd1,
        TIMED_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector; the delayed copy resets high so a line already high at
// reset release is not mistaken for an edge.
module rise_edge_det (
    input  logic in_clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic tick_d;

    always_ff @(posedge in_clk) begin
        if (rst) begin
            tick_d <= 1'b1;
        end else begin
            tick_d <= d;
        end
    end

    assign rise = d & ~tick_d;

endmodule

// File: rtl/tick_period_meter.sv
// Measures in_clk cycles between tick rising edges, with tolerance, lock and timeout.
// Optional min/max period tracking is enabled by defining TICK_MINMAX_EN.
module tick_period_meter
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EXPECTED    = 40000000,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned TIMEOUT_CYC = 80000000,
    parameter int unsigned LOCK_CNT    = 4
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             in_window,
    output logic             locked,
    output logic             timeout
`ifdef TICK_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
`endif
);

    localparam int unsigned LW = $clog2(LOCK_CNT + 1);
    // Wide enough that EXPECTED+TOL never wraps in the window compare.
    localparam int unsigned WW = 64;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LW-1:0]    lock_run;
    logic             tick_rise;

    logic [CNT_W-1:0] period_c;
    logic [WW-1:0]    period_w;
    logic             win_c;
    logic [LW-1:0]    lock_next_c;

    rise_edge_det u_rise (
        .in_clk (in_clk),
        .rst    (rst),
        .d      (tick_in),
        .rise   (tick_rise)
    );

    assign period_c = cnt + CNT_W'(1);
    assign period_w = WW'(period_c);
    assign win_c    = (period_w + WW'(TOL) >= WW'(EXPECTED)) &&
                      (period_w <= WW'(EXPECTED) + WW'(TOL));

    always_comb begin
        lock_next_c = '0;
        if (win_c) begin
            lock_next_c = (lock_run == LW'(LOCK_CNT)) ? lock_run : lock_run + LW'(1);
        end
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state        <= WAIT_FIRST;
            cnt          <= '0;
            lock_run     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_window    <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
`ifdef TICK_MINMAX_EN
            min_period   <= '1;
            max_period   <= '0;
`endif
        end else begin
            period_valid <= 1'b0;

            // Interval counter saturates so a dead tick line cannot wrap it.
            if (tick_rise) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(TIMEOUT_CYC)) begin
                cnt <= period_c;
            end

            case (state)
                WAIT_FIRST: begin
                    if (tick_rise) begin
                        state <= MEASURING;
                    end
                end
                MEASURING: begin
                    if (tick_rise) begin
                        period_out   <= period_c;
                        period_valid <= 1'b1;
                        in_window    <= win_c;
                        lock_run     <= lock_next_c;
                        locked       <= (lock_next_c == LW'(LOCK_CNT));
`ifdef TICK_MINMAX_EN
                        if (period_c < min_period) begin
                            min_period <= period_c;
                        end
                        if (period_c > max_period) begin
                            max_period <= period_c;
                        end
`endif
                    end else if (period_c == CNT_W'(TIMEOUT_CYC)) begin
                        state     <= TIMED_OUT;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        lock_run  <= '0;
                        in_window <= 1'b0;
                    end
                end
                TIMED_OUT: begin
                    // The interval spanning the outage is meaningless; restart measuring.
                    if (tick_rise) begin
                        state   <= MEASURING;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Self-checking bench for tick_period_meter: pulse table plus scoreboard of expected strobes.
module tb_tick_period_meter;

    localparam int unsigned CNT_W = 8;

    logic             in_clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             in_window;
    logic             locked;
    logic             timeout;
`ifdef TICK_MINMAX_EN
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;
`endif

    typedef struct {
        int period;
        bit win;
        bit lock;
    } exp_t;

    typedef struct {
        int gap;
        int width;
        bit strobe;
        int period;
        bit win;
        bit lock;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   checks   = 0;
    int   failures = 0;

    tick_period_meter #(
        .CNT_W       (CNT_W),
        .EXPECTED    (10),
        .TOL         (1),
        .TIMEOUT_CYC (25),
        .LOCK_CNT    (3)
    ) dut (
        .in_clk       (in_clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .in_window    (in_window),
        .locked       (locked),
        .timeout      (timeout)
`ifdef TICK_MINMAX_EN
        ,
        .min_period   (min_period),
        .max_period   (max_period)
`endif
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with tick_in at the given level; returns just after the edge.
    task automatic cyc(input logic t);
        tick_in = t;
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input int p, input bit w, input bit l);
        exp_t e;
        e.period = p;
        e.win    = w;
        e.lock   = l;
        sb.push_back(e);
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge in_clk) begin
        if (!rst && period_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_period", period_out, e.period);
                check("strobe_in_window", in_window, e.win);
                check("strobe_locked", locked, e.lock);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{10, 1, 0, 0, 0, 0};
        tbl[1]  = '{10, 1, 1, 10, 1, 0};
        tbl[2]  = '{10, 1, 1, 10, 1, 0};
        tbl[3]  = '{13, 1, 1, 10, 1, 1};
        tbl[4]  = '{9, 1, 1, 13, 0, 0};
        tbl[5]  = '{10, 5, 1, 9, 1, 0};
        tbl[6]  = '{10, 1, 1, 10, 1, 0};
        tbl[7]  = '{25, 1, 1, 10, 1, 1};
        tbl[8]  = '{10, 1, 1, 25, 0, 0};
        tbl[9]  = '{10, 1, 1, 10, 1, 0};
        tbl[10] = '{10, 1, 1, 10, 1, 0};
        tbl[11] = '{1, 1, 1, 10, 1, 1};

        // Reset with tick held high across release: must not count as an edge.
        rst = 1'b1;
        cyc(1);
        cyc(1);
        check("rst_period_out", period_out, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_in_window", in_window, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
`ifdef TICK_MINMAX_EN
        check("rst_min", min_period, 255);
        check("rst_max", max_period, 0);
`endif
        rst = 1'b0;
        cyc(1);
        cyc(1);
        repeat (3) cyc(0);

        // Lock, out-of-window, held-high pulse and exact-timeout-edge cases.
        begin
            bit saw_to;
            saw_to = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].strobe) push(tbl[i].period, tbl[i].win, tbl[i].lock);
                for (int k = 0; k < tbl[i].gap; k++) begin
                    cyc(k < tbl[i].width);
                    saw_to = saw_to | timeout;
                end
            end
            check("no_timeout_in_table", saw_to, 0);
        end
        check("locked_before_timeout", locked, 1);
`ifdef TICK_MINMAX_EN
        check("minmax_min", min_period, 9);
        check("minmax_max", max_period, 25);
`endif

        // Timeout: 25 cycles with no edge after the last rise.
        repeat (24) cyc(0);
        check("timeout_not_early", timeout, 0);
        cyc(0);
        check("timeout_fires", timeout, 1);
        check("timeout_locked", locked, 0);
        check("timeout_in_window", in_window, 0);
        check("timeout_period_hold", period_out, 10);
        repeat (5) cyc(0);
        check("timeout_sticky", timeout, 1);
        cyc(1);
        check("timeout_clears", timeout, 0);
        check("timeout_no_strobe", period_valid, 0);
        repeat (9) cyc(0);
        push(10, 1, 0);
        cyc(1);
`ifdef TICK_MINMAX_EN
        check("minmax_after_timeout_min", min_period, 9);
        check("minmax_after_timeout_max", max_period, 25);
`endif

        // Reset 4 cycles after an edge, then resume.
        repeat (3) cyc(0);
        rst = 1'b1;
        cyc(0);
        rst = 1'b0;
        check("midrst_period_out", period_out, 0);
        check("midrst_in_window", in_window, 0);
        check("midrst_locked", locked, 0);
        check("midrst_timeout", timeout, 0);
`ifdef TICK_MINMAX_EN
        check("midrst_min", min_period, 255);
        check("midrst_max", max_period, 0);
`endif
        repeat (3) cyc(0);
        cyc(1);
        check("post_rst_first_no_strobe", period_valid, 0);
        repeat (9) cyc(0);
        push(10, 1, 0);
        cyc(1);
        repeat (3) cyc(0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
